// File: rtl/pool_2_unit_pkg.sv
// pool_2_unit shared constants and FSM state type.
// Build option: POOL2_RELU_EN clamps pooled results at zero.
package pool_2_unit_pkg;

    localparam int DATA_W      = 8;
    localparam int COLS        = 24;
    localparam int HALF        = COLS / 2;
    localparam int ADDR_W      = 7;
    localparam int BANK_STRIDE = 2 * COLS;
    localparam int ROWS_OUT    = 12;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        CMP,
        OUT,
        RELEASE
    } state_t;

endpackage

// File: rtl/pool_2_unit_if.sv
// Bank handshake, buffer read port and pooled output stream.
// Build option: POOL2_RELU_EN (affects data only, not this bundle).
interface pool_2_unit_if;
    import pool_2_unit_pkg::*;

    logic [1:0]        bank_full;
    logic [1:0]        bank_free;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              out_ready;

    modport master (
        input  bank_full, rd_data, out_ready,
        output bank_free, rd_en, rd_addr,
        output out_valid, out_data, out_last
    );

    modport slave (
        output bank_full, rd_data, out_ready,
        input  bank_free, rd_en, rd_addr,
        input  out_valid, out_data, out_last
    );

endinterface

// File: rtl/pool_2_unit_max.sv
// Registered signed running maximum of one 2x2 window.
// Build option: POOL2_RELU_EN clamps a negative result to zero.
module pool_2_max
    import pool_2_unit_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              upd_i,
    input  logic [DATA_W-1:0] din_i,
    output logic [DATA_W-1:0] dout_o
);

    logic signed [DATA_W-1:0] max_q;
    logic signed [DATA_W-1:0] max_d;

    // First datum loads; later data replace only when strictly larger.
    always_comb begin
        max_d = max_q;
        if (load_i) begin
            max_d = din_i;
        end else if (upd_i && ($signed(din_i) > max_q)) begin
            max_d = din_i;
        end
    end

    // Running-max register, cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            max_q <= '0;
        end else begin
            max_q <= max_d;
        end
    end

`ifdef POOL2_RELU_EN
    assign dout_o = max_q[DATA_W-1] ? '0 : max_q;
`else
    assign dout_o = max_q;
`endif

endmodule

// File: rtl/pool_2_unit.sv
// 2x2 max-pool over the conv-2 ping-pong output buffer.
// Build option: POOL2_RELU_EN clamps pooled results at zero.
module pool_2_unit
    import pool_2_unit_pkg::*;
(
    input logic           clk,
    input logic           rst,
    pool_2_unit_if.master bus
);

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [3:0]  k_q, k_d;
    logic [3:0]  row_q, row_d;
    logic        bank_q, bank_d;
    logic        take_q, first_q;
    logic        last_k, last_row;
    logic [ADDR_W-1:0] base, addr;
    logic [DATA_W-1:0] max_out;

    assign last_k   = (k_q == 4'(HALF - 1));
    assign last_row = (row_q == 4'(ROWS_OUT - 1));

    // Window read order: row 0 pair, then row 1 pair.
    assign base = bank_q ? ADDR_W'(BANK_STRIDE) : '0;
    assign addr = base
                + (cnt_q[1] ? ADDR_W'(COLS) : '0)
                + {2'b00, k_q, 1'b0}
                + {{(ADDR_W-1){1'b0}}, cnt_q[0]};

    // State, counters and read-data qualifiers (one cycle behind rd_en).
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            k_q     <= '0;
            row_q   <= '0;
            bank_q  <= 1'b0;
            take_q  <= 1'b0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            k_q     <= k_d;
            row_q   <= row_d;
            bank_q  <= bank_d;
            take_q  <= (state_q == READ);
            first_q <= (state_q == READ) && (cnt_q == 2'd0);
        end
    end

    // Next-state logic and stream/read-port outputs.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        k_d           = k_q;
        row_d         = row_q;
        bank_d        = bank_q;
        bus.rd_en     = 1'b0;
        bus.rd_addr   = '0;
        bus.out_valid = 1'b0;
        bus.out_last  = 1'b0;
        bus.bank_free = 2'b00;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (bus.bank_full[bank_q]) begin
                    state_d = READ;
                end
            end
            READ: begin
                bus.rd_en   = 1'b1;
                bus.rd_addr = addr;
                cnt_d       = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    state_d = CMP;
                end
            end
            CMP: begin
                state_d = OUT;
            end
            OUT: begin
                bus.out_valid = 1'b1;
                bus.out_last  = last_row && last_k;
                if (bus.out_ready) begin
                    if (last_k) begin
                        k_d     = '0;
                        state_d = RELEASE;
                    end else begin
                        k_d     = k_q + 4'd1;
                        state_d = READ;
                    end
                end
            end
            RELEASE: begin
                bus.bank_free = bank_q ? 2'b10 : 2'b01;
                bank_d        = ~bank_q;
                row_d         = last_row ? '0 : row_q + 4'd1;
                state_d       = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    pool_2_max u_max (
        .clk    (clk),
        .rst    (rst),
        .load_i (take_q && first_q),
        .upd_i  (take_q && !first_q),
        .din_i  (bus.rd_data),
        .dout_o (max_out)
    );

    assign bus.out_data = max_out;

endmodule

// File: tb/tb_pool_2_unit.sv
// Directed bench for pool_2_unit.
// Honours POOL2_RELU_EN when computing expected bank-1 results.
module tb_pool_2_unit;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   viol = 0;
    logic prev_v = 1'b0;

    logic [7:0] mem [0:95];
    logic [7:0] s_data [$];
    logic       s_last [$];
    int         s_cyc [$];
    int         f_cyc [$];
    logic [1:0] f_val [$];
    int         rd_log [$];
    int         v_cyc [$];

    pool_2_unit_if bus ();

    pool_2_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];
    end

    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (bus.out_valid && bus.out_ready) begin
                s_data.push_back(bus.out_data);
                s_last.push_back(bus.out_last);
                s_cyc.push_back(cyc);
            end
            if (bus.bank_free != 2'b00) begin
                f_val.push_back(bus.bank_free);
                f_cyc.push_back(cyc);
            end
            if (bus.rd_en) rd_log.push_back(int'(bus.rd_addr));
            if (bus.rd_en && bus.out_valid) viol++;
            if (bus.out_valid && !prev_v) v_cyc.push_back(cyc);
        end
        prev_v = bus.out_valid;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_free(input int n, input string tag);
        for (int i = 0; i < 3000 && f_val.size() < n; i++) step(1);
        chk(tag, int'(f_val.size() >= n), 1);
    endtask

    task automatic wait_samples(input int n, input string tag);
        for (int i = 0; i < 3000 && s_data.size() < n; i++) step(1);
        chk(tag, int'(s_data.size() >= n), 1);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_rd_en"}, int'(bus.rd_en), 0);
        chk({tag, "_rd_addr"}, int'(bus.rd_addr), 0);
        chk({tag, "_valid"}, int'(bus.out_valid), 0);
        chk({tag, "_data"}, int'(bus.out_data), 0);
        chk({tag, "_last"}, int'(bus.out_last), 0);
        chk({tag, "_free"}, int'(bus.bank_free), 0);
    endtask

    function automatic int exp_b1(input int k);
        int v;
        v = (k == 0) ? -3 : 2 * k - 35;
`ifdef POOL2_RELU_EN
        v = 0;
`endif
        return v & 255;
    endfunction

    initial begin
        int t0;
        int nlast;
        int rd_mark;
        int s_mark;
        int found;

        rst           = 1'b0;
        bus.bank_full = 2'b00;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 48; i++) mem[i] = 8'(i);
        for (int j = 0; j < 48; j++) mem[48 + j] = 8'(j - 60);
        mem[48] = 8'hFB;
        mem[49] = 8'hFD;
        mem[72] = 8'hF8;
        mem[73] = 8'h9C;

        step(3);
        chk_reset("reset");
        rst = 1'b1;
        step(2);

        bus.bank_full = 2'b01;
        t0 = cyc;
        wait_free(1, "bank0_done");
        bus.bank_full = 2'b00;
        chk("latency", v_cyc[0] - t0, 6);
        for (int k = 0; k < 12; k++) begin
            chk($sformatf("b0_k%0d", k), int'(s_data[k]), 25 + 2 * k);
        end
        chk("b0_free", int'(f_val[0]), 1);
        chk("b0_free_t", f_cyc[0] - s_cyc[11], 1);

        bus.bank_full = 2'b10;
        wait_samples(15, "b1_pre_stall");
        bus.out_ready = 1'b0;
        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            if (bus.out_valid === 1'b1) found = 1;
            else step(1);
        end
        chk("stall_valid_seen", found, 1);
        rd_mark = rd_log.size();
        step(10);
        chk("stall_hold_data", int'(bus.out_data), exp_b1(3));
        chk("stall_hold_valid", int'(bus.out_valid), 1);
        chk("stall_no_rd", rd_log.size(), rd_mark);
        chk("stall_no_accept", s_data.size(), 15);
        bus.out_ready = 1'b1;
        wait_free(2, "bank1_done");
        bus.bank_full = 2'b00;
        for (int k = 0; k < 12; k++) begin
            chk($sformatf("b1_k%0d", k), int'(s_data[12 + k]), exp_b1(k));
        end
        chk("b1_free", int'(f_val[1]), 2);

        for (int b = 2; b < 13; b++) begin
            bus.bank_full = (b % 2 == 1) ? 2'b10 : 2'b01;
            wait_free(b + 1, $sformatf("bank%0d_done", b));
            bus.bank_full = 2'b00;
        end
        chk("frame_samples", s_data.size(), 156);
        nlast = 0;
        foreach (s_last[i]) if (s_last[i]) nlast++;
        chk("last_count", nlast, 1);
        chk("last_144", int'(s_last[143]), 1);
        chk("last_145", int'(s_last[144]), 0);
        chk("wrap_data", int'(s_data[144]), 25);
        chk("no_rd_while_valid", viol, 0);

        rst = 1'b0;
        step(2);
        s_data.delete();
        f_val.delete();
        rd_log.delete();
        bus.bank_full = 2'b11;
        rst = 1'b1;
        wait_free(1, "both_b0");
        bus.bank_full = 2'b10;
        wait_free(2, "both_b1");
        bus.bank_full = 2'b00;
        chk("both_free0", int'(f_val[0]), 1);
        chk("both_free1", int'(f_val[1]), 2);
        chk("both_rd0", rd_log[0], 0);
        chk("both_rd48", rd_log[48], 48);
        chk("both_data0", int'(s_data[0]), 25);

        rst = 1'b0;
        step(2);
        s_data.delete();
        f_val.delete();
        rd_log.delete();
        bus.bank_full = 2'b11;
        rst = 1'b1;
        wait_free(1, "abort_b0");
        bus.bank_full = 2'b10;
        found = 0;
        for (int i = 0; i < 500 && !found; i++) begin
            if (bus.rd_en === 1'b1 && int'(bus.rd_addr) == 58) found = 1;
            else step(1);
        end
        chk("abort_point", found, 1);
        rst = 1'b0;
        step(1);
        chk_reset("abort");
        step(2);
        chk("abort_no_free", f_val.size(), 1);
        rd_mark = rd_log.size();
        s_mark  = s_data.size();
        bus.bank_full = 2'b01;
        rst = 1'b1;
        wait_free(2, "restart_b0");
        bus.bank_full = 2'b00;
        chk("restart_rd0", rd_log[rd_mark], 0);
        chk("restart_free", int'(f_val[1]), 1);
        chk("restart_data", int'(s_data[s_mark]), 25);
        chk("final_no_rd_while_valid", viol, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
